// File: rtl/canny_ctrl_pkg.sv
// Shared widths, controller state encoding and the per-frame configuration record
// for the Canny NMS frame controller.
package canny_ctrl_pkg;

  localparam int DEF_W_DIM = 12;
  localparam int DEF_W_THR = 10;
  localparam int DEF_W_CNT = 22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [DEF_W_DIM-1:0] width;
    logic [DEF_W_DIM-1:0] height;
    logic [DEF_W_THR-1:0] hi;
    logic [DEF_W_THR-1:0] lo;
  } frame_cfg_t;

endpackage

// File: rtl/canny_geom_counter.sv
// Row/column tracker for the NMS output stream: border mask for the 3x3 window
// and a geometry-mismatch flag accumulated over the frame.
module canny_geom_counter
  import canny_ctrl_pkg::*;
#(
  parameter int W_DIM = DEF_W_DIM
) (
  input  logic             clk,
  input  logic             rst_s,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [W_DIM-1:0] i_width,
  input  logic [W_DIM-1:0] i_height,
  input  logic             i_href,
  input  logic             i_clken,
  output logic             o_mask,
  output logic             o_mismatch
);

  localparam logic [W_DIM-1:0] DIM_MAX = '1;

  logic [W_DIM-1:0] r_row;
  logic [W_DIM-1:0] r_col;
  logic             r_href_d;
  logic             r_line_err;
  logic             w_href_fall;
  logic             w_degen;

  assign w_href_fall = r_href_d & ~i_href;

  always_ff @(posedge clk) begin
    if (rst_s) begin
      r_row      <= '0;
      r_col      <= '0;
      r_href_d   <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_href_d <= i_href;
      if (i_clear) begin
        r_row      <= '0;
        r_col      <= '0;
        r_line_err <= 1'b0;
      end else if (i_enable) begin
        if (w_href_fall) begin
          r_col <= '0;
          if (r_row != DIM_MAX) r_row <= r_row + W_DIM'(1);
          if (r_col != i_width) r_line_err <= 1'b1;
        end else if (i_href && i_clken && (r_col != DIM_MAX)) begin
          r_col <= r_col + W_DIM'(1);
        end
      end
    end
  end

  // Below 3x3 the window never fits, so the whole frame is masked.
  assign w_degen    = (i_width < W_DIM'(3)) | (i_height < W_DIM'(3));
  assign o_mask     = w_degen
                    | (r_row == '0) | (r_row == i_height - W_DIM'(1))
                    | (r_col == '0) | (r_col == i_width - W_DIM'(1))
                    | (r_col >= i_width);
  assign o_mismatch = r_line_err | (r_row != i_height);

endmodule

// File: rtl/canny_nms_frame_ctrl.sv
// Frame controller after Canny NMS: double-buffered config applied at frame start,
// border masking, per-frame edge count and geometry check.
module canny_nms_frame_ctrl
  import canny_ctrl_pkg::*;
#(
  parameter int W_DIM = DEF_W_DIM,
  parameter int W_THR = DEF_W_THR,
  parameter int W_CNT = DEF_W_CNT
) (
  input  logic             clk,
  input  logic             rst_s,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [W_DIM-1:0] cfg_width,
  input  logic [W_DIM-1:0] cfg_height,
  input  logic [W_THR-1:0] cfg_hi_thr,
  input  logic [W_THR-1:0] cfg_lo_thr,
  input  logic             in_vsync,
  input  logic             in_href,
  input  logic             in_clken,
  input  logic [1:0]       in_max_g,
  output logic             out_vsync,
  output logic             out_href,
  output logic             out_clken,
  output logic [1:0]       out_max_g,
  output logic [W_THR-1:0] thr_hi,
  output logic [W_THR-1:0] thr_lo,
  output logic             frame_done,
  output logic [W_CNT-1:0] edge_count,
  output logic             geom_err
);

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  ctrl_state_t      r_state;
  frame_cfg_t       r_shadow;
  frame_cfg_t       r_active;
  logic             r_out_vsync;
  logic             r_out_href;
  logic             r_out_clken;
  logic [1:0]       r_out_max_g;
  logic             r_frame_done;
  logic             r_geom_err;
  logic [W_CNT-1:0] r_edge_count;
  logic [W_CNT-1:0] r_cnt_run;

  logic             w_cfg_accept;
  logic             w_vsync_rise;
  logic             w_vsync_fall;
  logic             w_clear;
  logic             w_enable;
  logic             w_mask;
  logic             w_mismatch;
  logic [1:0]       w_max_g;

  assign cfg_ready    = 1'b1;
  assign w_cfg_accept = cfg_valid & cfg_ready;
  // The delayed vsync output doubles as the edge-detect history.
  assign w_vsync_rise = in_vsync & ~r_out_vsync;
  assign w_vsync_fall = ~in_vsync & r_out_vsync;
  assign w_clear      = (r_state == ARMED) & w_vsync_rise;
  assign w_enable     = (r_state == ACTIVE);
  assign w_max_g      = (w_enable && !w_mask) ? in_max_g : 2'b00;

  canny_geom_counter #(
    .W_DIM (W_DIM)
  ) u_geom (
    .clk        (clk),
    .rst_s      (rst_s),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_width    (r_active.width),
    .i_height   (r_active.height),
    .i_href     (in_href),
    .i_clken    (in_clken),
    .o_mask     (w_mask),
    .o_mismatch (w_mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst_s) begin
      r_out_vsync <= 1'b0;
      r_out_href  <= 1'b0;
      r_out_clken <= 1'b0;
      r_out_max_g <= 2'b00;
    end else begin
      r_out_vsync <= in_vsync;
      r_out_href  <= in_href;
      r_out_clken <= in_clken;
      r_out_max_g <= w_max_g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_s) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_active     <= '0;
      r_cnt_run    <= '0;
      r_edge_count <= '0;
      r_geom_err   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_cfg_accept) begin
        r_shadow <= '{width: cfg_width, height: cfg_height, hi: cfg_hi_thr, lo: cfg_lo_thr};
      end
      case (r_state)
        IDLE: begin
          if (w_cfg_accept) r_state <= ARMED;
        end
        ARMED: begin
          // Old shadow is taken; a same-cycle accept waits for the next frame.
          if (w_vsync_rise) begin
            r_active  <= r_shadow;
            r_cnt_run <= '0;
            r_state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (in_clken && (w_max_g != 2'b00) && (r_cnt_run != CNT_MAX)) begin
            r_cnt_run <= r_cnt_run + W_CNT'(1);
          end
          if (w_vsync_fall) r_state <= DONE;
        end
        DONE: begin
          r_frame_done <= 1'b1;
          r_edge_count <= r_cnt_run;
          r_geom_err   <= w_mismatch;
          r_state      <= ARMED;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_vsync  = r_out_vsync;
  assign out_href   = r_out_href;
  assign out_clken  = r_out_clken;
  assign out_max_g  = r_out_max_g;
  assign thr_hi     = r_active.hi;
  assign thr_lo     = r_active.lo;
  assign frame_done = r_frame_done;
  assign edge_count = r_edge_count;
  assign geom_err   = r_geom_err;

endmodule

// File: tb/tb_canny_nms_frame_ctrl.sv
// Directed bench: a table of whole frames with hand-computed statistics, hand-written
// double-buffer and mid-frame reset sequences, and a per-cycle delay/mask monitor.
module tb_canny_nms_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_s;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [9:0]  cfg_hi_thr;
  logic [9:0]  cfg_lo_thr;
  logic        in_vsync;
  logic        in_href;
  logic        in_clken;
  logic [1:0]  in_max_g;
  logic        out_vsync;
  logic        out_href;
  logic        out_clken;
  logic [1:0]  out_max_g;
  logic [9:0]  thr_hi;
  logic [9:0]  thr_lo;
  logic        frame_done;
  logic [21:0] edge_count;
  logic        geom_err;

  int total = 0;
  int bad = 0;
  int done_cycles = 0;
  logic [1:0] exp_g;
  bit mid_en, rise_en;
  int mid_hi, mid_lo, rise_hi, rise_lo;

  bit         s_ok = 1'b0;
  logic       s_rst, s_vsync, s_href, s_clken;
  logic [1:0] s_g;

  typedef struct {
    bit do_cfg; int cw; int ch; int chi; int clo;
    int nl; int ll; int sl; int slen; int pat;
    bit live; int aw; int ah;
    int exp_done; int exp_cnt; int exp_err; int exp_hi; int exp_lo;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  canny_nms_frame_ctrl dut (
    .clk        (clk),
    .rst_s      (rst_s),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_hi_thr (cfg_hi_thr),
    .cfg_lo_thr (cfg_lo_thr),
    .in_vsync   (in_vsync),
    .in_href    (in_href),
    .in_clken   (in_clken),
    .in_max_g   (in_max_g),
    .out_vsync  (out_vsync),
    .out_href   (out_href),
    .out_clken  (out_clken),
    .out_max_g  (out_max_g),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .frame_done (frame_done),
    .edge_count (edge_count),
    .geom_err   (geom_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pass_px(input bit live, input int l, input int c, input int aw, input int ah);
    return live && aw >= 3 && ah >= 3 && l >= 1 && l <= ah - 2 && c >= 1 && c <= aw - 2;
  endfunction

  task automatic send_cfg(input int w, input int h, input int hi, input int lo);
    tick();
    cfg_valid  = 1'b1;
    cfg_width  = 12'(w);
    cfg_height = 12'(h);
    cfg_hi_thr = 10'(hi);
    cfg_lo_thr = 10'(lo);
    tick();
    cfg_valid = 1'b0;
  endtask

  // One frame of nl lines; line sl has slen pixels. A clken gap precedes pixel 3
  // of every line; on line rst_l that gap cycle carries a reset instead.
  task automatic drive_frame(input int nl, input int ll, input int sl, input int slen,
                             input int pat, input bit live_in, input int aw, input int ah,
                             input int rst_l, output logic [9:0] hi_seen, output logic [9:0] lo_seen);
    bit live;
    int len;
    logic [1:0] g;
    live = live_in;
    hi_seen = '0;
    lo_seen = '0;
    tick();
    in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0; in_max_g = 2'b00; exp_g = 2'b00;
    cfg_valid = 1'b0;
    tick();
    tick();
    in_vsync = 1'b1;
    if (rise_en) begin
      cfg_valid = 1'b1; cfg_width = 12'(aw); cfg_height = 12'(ah);
      cfg_hi_thr = 10'(rise_hi); cfg_lo_thr = 10'(rise_lo);
    end
    tick();
    cfg_valid = 1'b0;
    tick();
    for (int l = 0; l < nl; l++) begin
      len = (l == sl) ? slen : ll;
      for (int c = 0; c < len; c++) begin
        if (c == 3) begin
          tick();
          cfg_valid = 1'b0;
          in_clken = 1'b0;
          if (l == rst_l) begin
            rst_s = 1'b1; in_max_g = 2'b00; exp_g = 2'b00; live = 1'b0;
          end else begin
            in_max_g = 2'b11;
            exp_g = pass_px(live, l, 3, aw, ah) ? 2'b11 : 2'b00;
          end
        end
        tick();
        rst_s = 1'b0;
        cfg_valid = 1'b0;
        g = (pat == 0) ? 2'b10 : 2'((l + c) % 3);
        in_href = 1'b1; in_clken = 1'b1; in_max_g = g;
        exp_g = pass_px(live, l, c, aw, ah) ? g : 2'b00;
        if (mid_en && l == 1 && c == 0) begin
          cfg_valid = 1'b1; cfg_width = 12'(aw); cfg_height = 12'(ah);
          cfg_hi_thr = 10'(mid_hi); cfg_lo_thr = 10'(mid_lo);
        end
        if (l == 0 && c == 0) begin
          hi_seen = thr_hi;
          lo_seen = thr_lo;
        end
      end
      tick();
      cfg_valid = 1'b0; in_href = 1'b0; in_clken = 1'b0; in_max_g = 2'b00; exp_g = 2'b00;
      tick();
    end
    tick();
    in_vsync = 1'b0;
    repeat (4) tick();
  endtask

  // Outputs at this falling edge must reflect the inputs captured one cycle earlier.
  always @(negedge clk) begin
    if (s_ok) begin
      if (s_rst) begin
        chk("reset_outputs",
            64'({out_vsync, out_href, out_clken, out_max_g, thr_hi, thr_lo,
                 frame_done, edge_count, geom_err}), 64'(0));
      end else begin
        chk("vsync_delay", 64'(out_vsync), 64'(s_vsync));
        chk("href_delay", 64'(out_href), 64'(s_href));
        chk("clken_delay", 64'(out_clken), 64'(s_clken));
        chk("max_g_masked", 64'(out_max_g), 64'(s_g));
      end
      chk("cfg_ready", 64'(cfg_ready), 64'(1));
    end
    if (frame_done === 1'b1) done_cycles++;
    s_rst = rst_s; s_vsync = in_vsync; s_href = in_href; s_clken = in_clken; s_g = exp_g;
    s_ok = 1'b1;
  end

  initial begin
    logic [9:0] hs, ls;
    int d0;
    rst_s = 1'b1; cfg_valid = 1'b0; cfg_width = '0; cfg_height = '0;
    cfg_hi_thr = '0; cfg_lo_thr = '0; in_vsync = 1'b0; in_href = 1'b0;
    in_clken = 1'b0; in_max_g = 2'b00; exp_g = 2'b00;
    mid_en = 1'b0; rise_en = 1'b0; mid_hi = 0; mid_lo = 0; rise_hi = 0; rise_lo = 0;

    //          cfg cw ch  hi  lo  nl ll  sl slen pat live aw ah done cnt err  hi  lo
    vecs[0] = '{0, 0, 0,  0,  0,  4, 8, -1, 0,  0,  0,  8, 4, 0,   0, 0,   0,  0};
    vecs[1] = '{1, 8, 4, 200,100, 4, 8, -1, 0,  0,  1,  8, 4, 1,  12, 0, 200,100};
    vecs[2] = '{0, 0, 0,  0,  0,  4, 8,  1, 7,  0,  1,  8, 4, 1,  12, 1, 200,100};
    vecs[3] = '{0, 0, 0,  0,  0,  4, 8, -1, 0,  1,  1,  8, 4, 1,   8, 0, 200,100};
    vecs[4] = '{1,10, 5, 300,150, 5,10, -1, 0,  0,  1, 10, 5, 1,  24, 0, 300,150};
    vecs[5] = '{0, 0, 0,  0,  0,  4,10, -1, 0,  0,  1, 10, 5, 1,  24, 1, 300,150};
    vecs[6] = '{0, 0, 0,  0,  0,  5,10,  2,12,  0,  1, 10, 5, 1,  24, 1, 300,150};
    vecs[7] = '{1, 2, 5,  7,  3,  5, 2, -1, 0,  0,  1,  2, 5, 1,   0, 0,   7,  3};
    vecs[8] = '{1, 6, 2,  9,  4,  2, 6, -1, 0,  1,  1,  6, 2, 1,   0, 0,   9,  4};

    repeat (3) tick();
    rst_s = 1'b0;
    tick();
    chk("rst_thr_hi", 64'(thr_hi), 64'(0));
    chk("rst_edge_count", 64'(edge_count), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_cfg) send_cfg(vecs[i].cw, vecs[i].ch, vecs[i].chi, vecs[i].clo);
      d0 = done_cycles;
      drive_frame(vecs[i].nl, vecs[i].ll, vecs[i].sl, vecs[i].slen, vecs[i].pat,
                  vecs[i].live, vecs[i].aw, vecs[i].ah, -1, hs, ls);
      chk($sformatf("v%0d_done_pulses", i), 64'(done_cycles - d0), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_edge_count", i), 64'(edge_count), 64'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_geom_err", i), 64'(geom_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_thr_hi", i), 64'(hs), 64'(vecs[i].exp_hi));
      chk($sformatf("v%0d_thr_lo", i), 64'(ls), 64'(vecs[i].exp_lo));
    end

    // Double buffering: mid-frame accept, then an accept on the vsync-rise cycle.
    send_cfg(8, 4, 200, 100);
    mid_en = 1'b1; mid_hi = 50; mid_lo = 25;
    d0 = done_cycles;
    drive_frame(4, 8, -1, 0, 0, 1'b1, 8, 4, -1, hs, ls);
    mid_en = 1'b0;
    chk("db1_thr_hi", 64'(hs), 64'(200));
    chk("db1_thr_hi_end", 64'(thr_hi), 64'(200));
    chk("db1_edge_count", 64'(edge_count), 64'(12));
    chk("db1_done_pulses", 64'(done_cycles - d0), 64'(1));
    rise_en = 1'b1; rise_hi = 60; rise_lo = 30;
    drive_frame(4, 8, -1, 0, 0, 1'b1, 8, 4, -1, hs, ls);
    rise_en = 1'b0;
    chk("db2_thr_hi", 64'(hs), 64'(50));
    chk("db2_thr_lo", 64'(ls), 64'(25));
    drive_frame(4, 8, -1, 0, 0, 1'b1, 8, 4, -1, hs, ls);
    chk("db3_thr_hi", 64'(hs), 64'(60));
    chk("db3_thr_lo", 64'(ls), 64'(30));

    // Reset in the middle of row 2; the remainder and the next frame stay masked.
    d0 = done_cycles;
    drive_frame(4, 8, -1, 0, 0, 1'b1, 8, 4, 2, hs, ls);
    chk("rstmid_done_pulses", 64'(done_cycles - d0), 64'(0));
    chk("rstmid_edge_count", 64'(edge_count), 64'(0));
    chk("rstmid_thr_hi", 64'(thr_hi), 64'(0));
    chk("rstmid_geom_err", 64'(geom_err), 64'(0));
    drive_frame(4, 8, -1, 0, 0, 1'b0, 8, 4, -1, hs, ls);
    chk("idle_done_pulses", 64'(done_cycles - d0), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canny_nms_frame_ctrl.md
Name: canny_nms_frame_ctrl

Overview:
Frame-level controller placed directly after the Canny non-maximum-suppression stage and ahead of double thresholding.
- Accepts per-frame configuration (geometry, hi/lo thresholds) through a valid/ready handshake and double-buffers it.
- Applies the new configuration only at frame boundaries.
- Tracks row/column position of the NMS output stream and forces border pixels to zero, since the 3x3 window is invalid there.
- Reports per-frame edge statistics and geometry errors.

Parameters:
- W_DIM, 12, width of image dimension fields and row/col counters
- W_THR, 10, threshold width; matches the gradient magnitude field
- W_CNT, 22, width of the per-frame edge counter (saturating)

Ports:
- clk  in  1  system clock
- rst_s  in  1  synchronous reset, active-high
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_width  in  W_DIM  active pixels per line
- cfg_height  in  W_DIM  active lines per frame
- cfg_hi_thr  in  W_THR  high threshold for the downstream stage
- cfg_lo_thr  in  W_THR  low threshold for the downstream stage
- in_vsync  in  1  NMS output vsync, high during the frame
- in_href  in  1  NMS output line valid
- in_clken  in  1  NMS output pixel strobe
- in_max_g  in  2  NMS result; 0 means suppressed
- out_vsync  out  1  in_vsync delayed 1 cycle
- out_href  out  1  in_href delayed 1 cycle
- out_clken  out  1  in_clken delayed 1 cycle
- out_max_g  out  2  border-masked NMS result
- thr_hi  out  W_THR  active high threshold
- thr_lo  out  W_THR  active low threshold
- frame_done  out  1  one-cycle pulse after frame end; statistics valid
- edge_count  out  W_CNT  edge pixels in the last completed frame
- geom_err  out  1  last completed frame did not match the configured geometry

Behaviour:
- Reset values: all outputs 0, except cfg_ready = 1. State IDLE, shadow and active registers cleared.
- A configuration is accepted on any cycle where cfg_valid && cfg_ready. cfg_ready is constant 1 in every state. A new accept overwrites the shadow register; last write wins.
- FSM states:
  - IDLE: no configuration yet. out_max_g is forced to 0. An accept moves to ARMED.
  - ARMED: on the rising edge of in_vsync, copy shadow to active (thr_hi, thr_lo, width, height), clear counters, go to ACTIVE.
  - ACTIVE: on the falling edge of in_vsync, go to DONE.
  - DONE: held 1 cycle. Pulse frame_done, publish edge_count and geom_err, return to ARMED.
- A config accepted in the same cycle as the vsync rise lands in the shadow register only. It takes effect at the next frame.
- An in_vsync rise seen while in IDLE is ignored; that frame is fully masked.
- Datapath latency is exactly 1 cycle for vsync, href, clken and max_g in all states.
- Counters (ACTIVE only):
  - col increments on each in_clken with in_href, and clears on the href falling edge.
  - row increments on the href falling edge.
  - Both counters saturate at 2^W_DIM-1; no wrap.
- Masking: out_max_g = 0 when row==0, row==height-1, col==0, col==width-1, or col>=width. Otherwise out_max_g = in_max_g.
- edge_count: running count of out_clken beats with out_max_g!=0. Saturates at 2^W_CNT-1. Published at DONE and held until the next DONE.
- geom_err is set at DONE if either of the following held during the frame:
  - any line ended with col != width;
  - final row != height.
  It holds until the next DONE.
- Degenerate geometry: width<3 or height<3 means every pixel is masked. No error from that alone.
- Reset mid-frame: immediate return to IDLE and reset values. The partial frame yields no frame_done.

Decomposition:
- Package canny_ctrl_pkg: W_DIM, W_THR and W_CNT defaults, the FSM state encoding (IDLE, ARMED, ACTIVE, DONE), and the config record type {width, height, hi, lo}.
- One sub-module, canny_geom_counter: row/col counters, href edge detect, border-mask and mismatch flags.

Test Plan:
- Reset, cfg 8x4 with hi=200, lo=100, one frame with all in_max_g=2'b10 -> interior 6x2 passes. frame_done pulses once; edge_count=12, geom_err=0, thr_hi=200, thr_lo=100 from first pixel.
- Same frame before any cfg accepted -> out_max_g all 0, no frame_done, stays IDLE.
- cfg 8x4 then frame with line 2 only 7 pixels -> geom_err=1 at DONE; a correct next frame clears it to 0.
- Config A (hi=200) active; cfg B (hi=50) accepted mid-frame and another B' (hi=60) on the vsync-rise cycle -> thr_hi stays 200 for the current frame, becomes 50 next frame, and 60 the frame after.
- rst_s asserted mid-frame at row 2 -> next cycle all outputs 0, state IDLE. Rest of the frame is masked with no frame_done.
- Check every cycle that out_* equals in_* delayed one cycle, except for masked max_g.
